// File: rtl/present_if.sv
// present_if -- request/response bundle for present_core.
// The master side launches an operation (start/mode/data_in/key) and
// observes ready/done/data_out; the slave side is the cipher core.
interface present_if #(
    parameter int KEY_W = 80
);
    logic             start;
    logic             mode;
    logic [63:0]      data_in;
    logic [KEY_W-1:0] key;
    logic             ready;
    logic             done;
    logic [63:0]      data_out;

    modport master (
        output start, mode, data_in, key,
        input  ready, done, data_out
    );

    modport slave (
        input  start, mode, data_in, key,
        output ready, done, data_out
    );
endinterface

// File: rtl/present_core.sv
// present_core -- iterative PRESENT block cipher (64-bit block, 80- or
// 128-bit key), one round per clock.
// Encrypt: E0 captures operands, E1..E31 run rounds, E32 applies K32
// whitening and pulses done.
// Optional feature macro: PRESENT_DECRYPT_EN compiles in decryption
// (EXPAND walks the key forward to K32, then whitening + 31 inverse rounds,
// done after E63). Without it, mode is ignored and only encrypt exists.
module present_core #(
    parameter int KEY_W = 80
) (
    input  logic     clk,
    input  logic     reset,
    present_if.slave bus
);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_core: KEY_W must be 80 or 128");
    end

    // Low bit of the 5-bit round-counter field inside the key register.
    localparam int CTR_LO = (KEY_W == 128) ? 62 : 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
`ifdef PRESENT_DECRYPT_EN
        ST_EXPAND = 2'd3,
`endif
        ST_FINAL  = 2'd2
    } state_e;

    state_e           state_r, state_s;
    logic [63:0]      data_r, data_s;
    logic [KEY_W-1:0] key_r, key_s;
    logic [4:0]       cnt_r, cnt_s;
    logic [63:0]      dout_r, dout_s;
    logic             done_r, done_s;
    logic             ready_r, ready_s;
`ifdef PRESENT_DECRYPT_EN
    logic             mode_r, mode_s;
    logic             first_r, first_s;   // next decrypt ROUND edge is the K32 whitening
`else
    logic             unused_mode_s;
    assign unused_mode_s = bus.mode;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    // Bit i moves to 16*(i mod 4) + i/4.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 64; i++) y[16*(i%4) + i/4] = x[i];
        return y;
    endfunction

    // Derive K(i+1) from K(i) using round counter c = i.
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] c);
        logic [KEY_W-1:0] r;
        r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
        r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
        r[KEY_W-5 -: 4] = (KEY_W == 128) ? sbox(r[KEY_W-5 -: 4]) : r[KEY_W-5 -: 4];
        r[CTR_LO +: 5]  = r[CTR_LO +: 5] ^ c;
        return r;
    endfunction

`ifdef PRESENT_DECRYPT_EN
    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 64; i++) y[i] = x[16*(i%4) + i/4];
        return y;
    endfunction

    // Recover K(i) from K(i+1) using round counter c = i.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] c);
        logic [KEY_W-1:0] r;
        r = k;
        r[CTR_LO +: 5]  = r[CTR_LO +: 5] ^ c;
        r[KEY_W-1 -: 4] = inv_sbox(r[KEY_W-1 -: 4]);
        r[KEY_W-5 -: 4] = (KEY_W == 128) ? inv_sbox(r[KEY_W-5 -: 4]) : r[KEY_W-5 -: 4];
        return {r[60:0], r[KEY_W-1:61]};
    endfunction
`endif

    // Next-state and datapath computation for every register.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        key_s   = key_r;
        cnt_s   = cnt_r;
        dout_s  = dout_r;
        done_s  = 1'b0;
`ifdef PRESENT_DECRYPT_EN
        mode_s  = mode_r;
        first_s = first_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    data_s = bus.data_in;
                    key_s  = bus.key;
                    cnt_s  = 5'd1;
`ifdef PRESENT_DECRYPT_EN
                    mode_s  = bus.mode;
                    first_s = 1'b1;
                    state_s = bus.mode ? ST_EXPAND : ST_ROUND;
`else
                    state_s = ST_ROUND;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef PRESENT_DECRYPT_EN
            ST_EXPAND: begin
                key_s = key_fwd(key_r, cnt_r);
                if (cnt_r == 5'd31) begin
                    state_s = ST_ROUND;   // key now holds K32, counter parks at 31
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end
`endif
            ST_ROUND: begin
`ifdef PRESENT_DECRYPT_EN
                if (mode_r) begin
                    if (first_r) begin
                        data_s  = data_r ^ key_r[KEY_W-1 -: 64];
                        key_s   = key_inv(key_r, cnt_r);
                        first_s = 1'b0;
                    end else begin
                        data_s = inv_s_layer(inv_p_layer(data_r)) ^ key_r[KEY_W-1 -: 64];
                        if (cnt_r == 5'd1) begin
                            dout_s  = data_s;
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            key_s = key_inv(key_r, cnt_r - 5'd1);
                            cnt_s = cnt_r - 5'd1;
                        end
                    end
                end else
`endif
                begin
                    data_s = p_layer(s_layer(data_r ^ key_r[KEY_W-1 -: 64]));
                    key_s  = key_fwd(key_r, cnt_r);
                    if (cnt_r == 5'd31) begin
                        state_s = ST_FINAL;   // counter saturates, never wraps
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
            end
            ST_FINAL: begin
                dout_s  = data_r ^ key_r[KEY_W-1 -: 64];
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            data_r  <= 64'h0;
            key_r   <= {KEY_W{1'b0}};
            cnt_r   <= 5'd0;
            dout_r  <= 64'h0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
`ifdef PRESENT_DECRYPT_EN
            mode_r  <= 1'b0;
            first_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            key_r   <= key_s;
            cnt_r   <= cnt_s;
            dout_r  <= dout_s;
            done_r  <= done_s;
            ready_r <= ready_s;
`ifdef PRESENT_DECRYPT_EN
            mode_r  <= mode_s;
            first_r <= first_s;
`endif
        end
    end

    assign bus.ready    = ready_r;
    assign bus.done     = done_r;
    assign bus.data_out = dout_r;

endmodule
